// File: rtl/step_sequencer.sv
// step_sequencer: T-state step counter for the 8-bit CPU control unit.
// Drives the control-ROM step field, one-hot decode, fetch flag, done pulse.
// Ports: clk, rst_n (async low), ena, hlt, nxt, step_mode, step_btn
//        -> step, step_onehot, fetch, instr_done, halted.
// Optional macro SINGLE_STEP_EN: synchronised manual single-step button.
module step_sequencer #(
   parameter int STEP_BITS   = 3,
   parameter int MAX_STEP    = 5,
   parameter int FETCH_STEPS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      hlt,
   input  logic                      nxt,
   input  logic                      step_mode,
   input  logic                      step_btn,
   output logic [STEP_BITS-1:0]      step,
   output logic [2**STEP_BITS-1:0]   step_onehot,
   output logic                      fetch,
   output logic                      instr_done,
   output logic                      halted
);

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [STEP_BITS-1:0] r_step;
   logic [STEP_BITS-1:0] w_step_nxt;
   logic                 r_done;
   logic                 w_done_nxt;
   logic                 w_gate;
   logic                 w_adv;
   logic                 w_last;

`ifdef SINGLE_STEP_EN
   logic r_sync1;
   logic r_sync2;
   logic r_sync3;
   logic w_pulse;

   // Synchroniser runs freely so edges seen while stalled are lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= step_btn;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_pulse = r_sync2 & ~r_sync3;
   assign w_gate  = ~step_mode | w_pulse;
`else
   logic w_unused;
   assign w_unused = &{1'b0, step_mode, step_btn};
   assign w_gate   = 1'b1;
`endif

   assign w_adv  = ena & (r_state == S_RUN) & w_gate;
   assign w_last = (r_step == STEP_BITS'(MAX_STEP));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_RUN;
         r_step  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Next state: halt beats early restart, which beats increment
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      w_done_nxt  = 1'b0;
      if (w_adv) begin
         if (hlt) begin
            w_state_nxt = S_HALTED;
         end else if (nxt || w_last) begin
            w_step_nxt = '0;
            w_done_nxt = 1'b1;
         end else begin
            w_step_nxt = r_step + STEP_BITS'(1);
         end
      end
   end

   // Outputs
   always_comb begin
      step_onehot         = '0;
      step_onehot[r_step] = 1'b1;
      fetch               = (int'(r_step) < FETCH_STEPS);
      halted              = (r_state == S_HALTED);
   end

   assign step       = r_step;
   assign instr_done = r_done;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed + random checks of step_sequencer
// against a behavioural model of the step/halt/done rules.
module tb_step_sequencer;

   localparam int MAXS = 5;
   localparam int FST  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       hlt = 1'b0;
   logic       nxt = 1'b0;
   logic       step_mode = 1'b0;
   logic       step_btn = 1'b0;
   logic [2:0] step;
   logic [7:0] step_onehot;
   logic       fetch;
   logic       instr_done;
   logic       halted;

   int n_checks = 0;
   int n_errors = 0;

   int m_step = 0;
   bit m_halt = 1'b0;
   bit m_done = 1'b0;
   bit bh[$];

   step_sequencer dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .hlt(hlt), .nxt(nxt),
      .step_mode(step_mode), .step_btn(step_btn),
      .step(step), .step_onehot(step_onehot), .fetch(fetch),
      .instr_done(instr_done), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("step", 32'(step), 32'(m_step));
      check("onehot", 32'(step_onehot), 32'(1) << m_step);
      check("fetch", 32'(fetch), 32'(m_step < FST));
      check("instr_done", 32'(instr_done), 32'(m_done));
      check("halted", 32'(halted), 32'(m_halt));
   endtask

   function automatic void model_reset();
      m_step = 0;
      m_halt = 1'b0;
      m_done = 1'b0;
      bh = '{1'b0, 1'b0, 1'b0};
   endfunction

   // Button history: pulse at this edge if btn was sampled high two
   // edges ago and low three edges ago (2-flop sync + edge detect).
   function automatic void model_edge();
      bit pulse;
      bit adv;
      bh.push_back(step_btn);
      if (bh.size() > 8) void'(bh.pop_front());
      pulse = bh[bh.size()-3] && !bh[bh.size()-4];
`ifdef SINGLE_STEP_EN
      adv = ena && !m_halt && (!step_mode || pulse);
`else
      adv = ena && !m_halt;
`endif
      m_done = 1'b0;
      if (adv) begin
         if (hlt) m_halt = 1'b1;
         else if (nxt || m_step == MAXS) begin
            m_step = 0;
            m_done = 1'b1;
         end else m_step = m_step + 1;
      end
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all();
      rst_n = 1'b1;
      #1;
   endtask

   int exp_seq[7] = '{1, 2, 3, 4, 5, 0, 1};

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // 1: free run with wrap
      ena = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("seq_step", 32'(step), 32'(exp_seq[i]));
         check("seq_done", 32'(instr_done), 32'(i == 5));
      end

      // 2: early restart at step 2
      tick();
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
      check("nxt_onehot", 32'(step_onehot), 32'h1);
      check("nxt_done", 32'(instr_done), 32'h1);

      // 3: halt at step 3, nxt toggling ignored
      for (int i = 0; i < 3; i++) tick();
      hlt = 1'b1;
      tick();
      hlt = 1'b0;
      for (int i = 0; i < 50; i++) begin
         nxt = i[0];
         tick();
      end
      nxt = 1'b0;
      check("halt_step", 32'(step), 32'h3);
      check("halt_flag", 32'(halted), 32'h1);
      do_reset();

      // 4: stall at step 1
      tick();
      ena = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("stall_step", 32'(step), 32'h1);
      ena = 1'b1;
      tick();
      check("resume_step", 32'(step), 32'h2);

      // 6: async reset between edges at step 4
      tick();
      tick();
      do_reset();

`ifdef SINGLE_STEP_EN
      // 5: single-step mode
      step_mode = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      step_btn = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      step_btn = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("single_step", 32'(step), 32'h1);
      step_mode = 1'b0;
`endif

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         ena       = ($urandom_range(0, 9) != 0);
         hlt       = ($urandom_range(0, 60) == 0);
         nxt       = ($urandom_range(0, 5) == 0);
         step_mode = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
         if ($urandom_range(0, 120) == 0) do_reset();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
